mccp_videocard_core: RTL and testbench
======================================

Name: mccp_videocard_core

Overview:
- Memory-mapped compute engine ("video card") for the MCCP SoC.
- A host bus slave port loads an instruction memory and a shared data RAM.
- A small control port starts a simple 32-bit multicycle core. The core runs from PC 0 until HALT, reading and writing the data RAM, then reports done.

Parameters:
WIDTH, 32, data/instruction word width
IMEM_AW, 6, instruction memory address bits (64 words)
DMEM_AW, 8, data RAM address bits (256 words)

Ports:
clk  in  1  single system clock; all logic on rising edge
reset_sink_reset  in  1  synchronous active-high reset
address  in  17  host address; bit16=1 selects instruction memory (bits[IMEM_AW-1:0]), bit16=0 selects data RAM (bits[DMEM_AW-1:0])
data_in  in  32  host write data
data_out  out  32  host read data
byteenable  in  4  per-byte write enable; bit i covers bits[8i+7:8i]
write  in  1  host write strobe
read  in  1  host read strobe
address_control  in  1  control register select: 0=CTRL, 1=STATUS
data_in_control  in  32  control write data
data_out_control  out  32  control read data
write_control  in  1  control write strobe
read_control  in  1  control read strobe

Behaviour:
- Reset clears PC, R0-R7, busy, done, data_out and data_out_control to 0. Memory contents are not cleared. Reset mid-run aborts the run and returns the core to IDLE.
- Host writes take effect at the clock edge where write=1 and honour byteenable.
- Host reads have 1-cycle latency. data_out is registered from the selected memory when read=1 and holds otherwise.
- Data RAM is dual-port: port A is host, port B is core. On a same-cycle same-address write, the core write wins. Host writes are accepted at all times.
- Control writes:
  - CTRL with data_in_control[0]=1 while not busy: PC<=0, busy<=1, done<=0, next state FETCH.
  - CTRL writes while busy are ignored.
  - STATUS is read-only.
- Control reads have 1-cycle latency when read_control=1:
  - CTRL returns {31'b0, busy}.
  - STATUS returns {done, 15'b0, 10'b0, PC[5:0]}.
- Instruction format: [31:28] op, [27:25] rd, [24:22] ra, [21:19] rb, [15:0] imm. sext denotes 16-to-32 sign extension.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd=sext(imm).
  - 2 LD: rd=RAM[ra+sext(imm)].
  - 3 ST: RAM[ra+sext(imm)]=rd.
  - 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR: rd=ra op rb.
  - 9 SHL: rd=ra<<rb[4:0]. A SHR (logical): rd=ra>>rb[4:0].
  - B ADDI: rd=ra+sext(imm).
  - C BEQ: if ra==rb then PC=imm[IMEM_AW-1:0].
  - D BNE: if ra!=rb then PC=imm[IMEM_AW-1:0].
  - E JMP: PC=imm[IMEM_AW-1:0].
  - F HALT: busy<=0, done<=1.
- Arithmetic is modulo 2^32. RAM addresses use the low DMEM_AW bits of the sum; the IMEM PC wraps at 2^IMEM_AW.
- R0 is an ordinary register; it is not hardwired to zero.
- FSM:
  - IDLE -> FETCH on start.
  - FETCH issues IMEM[PC]; the synchronous read returns next cycle.
  - EXEC executes the instruction. PC<=PC+1 unless a branch is taken or the instruction is HALT. LD goes to MEM; HALT goes to IDLE; all others go to FETCH.
  - MEM writes rd from the RAM output, then goes to FETCH.
  - Cost: 2 cycles per instruction, 3 for LD.
- done stays set until the next start or reset.

Test Plan:
- Reset, then read STATUS and CTRL -> both 0; data_out=0.
- Write IMEM 65536..65540 with: LDI R1,5; LDI R2,7; ADD R3,R1,R2; ST R3 at [R0+20] with R0=0; HALT. Write CTRL=1 -> after 10 cycles busy=0, done=1, host read of RAM[20] returns 12 one cycle after read.
- Sum loop: RAM[0]=4, RAM[1..4]=3,4,5,6, program sums RAM[1..RAM[0]] into RAM[5] -> RAM[5]=18, done=1.
- byteenable=4'b0010 write of 0xAABBCCDD over RAM[7]=0 -> RAM[7]=0x0000CC00.
- CTRL=1 written while busy -> ignored. PC continues; after completion, a new CTRL=1 clears done and reruns from PC 0.
- Assert reset_sink_reset mid-program -> next cycle busy=0, done=0, PC=0. RAM contents written so far persist.

Source files
------------

// File: rtl/mccp_videocard_core.sv
// mccp_videocard_core: memory-mapped compute engine for the MCCP SoC.
//
// The host loads an instruction memory (IMEM) and a shared data RAM (DMEM)
// through the host port. It then starts a small 32-bit multicycle core
// through the control port. The core runs from PC 0 until HALT and reads
// and writes the data RAM along the way.
//
// Ports
//   clk, reset_sink_reset   system clock, synchronous active-high reset
//   address[16:0]           bit16=1 selects IMEM, bit16=0 selects DMEM
//   data_in, byteenable     host write data and per-byte enables
//   write, read             host strobes; a read returns one cycle later
//   data_out                registered host read data
//   address_control         0=CTRL, 1=STATUS
//   data_in_control         CTRL write data; bit0=1 starts the core
//   write_control           control write strobe
//   read_control            control read strobe; returns one cycle later
//   data_out_control        registered control read data
//
// state  | meaning
// IDLE   | waiting for a start
// FETCH  | IMEM[pc] is being read into the instruction register
// EXEC   | decode and execute; LD also issues the RAM read
// MEM    | LD writeback from the RAM read data
module mccp_videocard_core #(
  parameter int WIDTH   = 32,
  parameter int IMEM_AW = 6,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset_sink_reset,
  input  logic [16:0]        address,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  input  logic [WIDTH/8-1:0] byteenable,
  input  logic               write,
  input  logic               read,
  input  logic               address_control,
  input  logic [WIDTH-1:0]   data_in_control,
  output logic [WIDTH-1:0]   data_out_control,
  input  logic               write_control,
  input  logic               read_control
);

  localparam int NB = WIDTH / 8;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   imem [2**IMEM_AW];
  logic [WIDTH-1:0]   dmem [2**DMEM_AW];
  logic [WIDTH-1:0]   regs [8];
  logic [WIDTH-1:0]   ir;
  logic [WIDTH-1:0]   dmem_q;
  logic [IMEM_AW-1:0] pc;
  logic               busy;
  logic               done;

  logic [3:0]         op;
  logic [2:0]         rd, ra, rb;
  logic [15:0]        imm16;
  logic [WIDTH-1:0]   simm, va, vb, ea, alu_res;
  logic [DMEM_AW-1:0] core_addr;
  logic               wr_rd, taken, core_we, start;

  assign op        = ir[31:28];
  assign rd        = ir[27:25];
  assign ra        = ir[24:22];
  assign rb        = ir[21:19];
  assign imm16     = ir[15:0];
  assign simm      = {{(WIDTH-16){imm16[15]}}, imm16};
  assign va        = regs[ra];
  assign vb        = regs[rb];
  assign ea        = va + simm;
  assign core_addr = ea[DMEM_AW-1:0];

  // busy is only clear in IDLE, so a start can never collide with EXEC/MEM.
  assign start = write_control && !address_control && data_in_control[0] && !busy;

  logic unused_bits;
  assign unused_bits = ^{ir[18:16], ea[WIDTH-1:DMEM_AW], address[15:DMEM_AW],
                         data_in_control[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset_sink_reset) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_we   = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        core_we = (op == OP_ST);
        if (op == OP_LD)        state_nxt = S_MEM;
        else if (op == OP_HALT) state_nxt = S_IDLE;
        else                    state_nxt = S_FETCH;
      end
      S_MEM:   state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    wr_rd   = 1'b0;
    taken   = 1'b0;
    case (op)
      OP_LDI:  begin alu_res = simm;            wr_rd = 1'b1; end
      OP_ADD:  begin alu_res = va + vb;         wr_rd = 1'b1; end
      OP_SUB:  begin alu_res = va - vb;         wr_rd = 1'b1; end
      OP_AND:  begin alu_res = va & vb;         wr_rd = 1'b1; end
      OP_OR:   begin alu_res = va | vb;         wr_rd = 1'b1; end
      OP_XOR:  begin alu_res = va ^ vb;         wr_rd = 1'b1; end
      OP_SHL:  begin alu_res = va << vb[4:0];   wr_rd = 1'b1; end
      OP_SHR:  begin alu_res = va >> vb[4:0];   wr_rd = 1'b1; end
      OP_ADDI: begin alu_res = ea;              wr_rd = 1'b1; end
      OP_BEQ:  taken = (va == vb);
      OP_BNE:  taken = (va != vb);
      OP_JMP:  taken = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_sink_reset) begin
      pc   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (start) begin
        pc   <= '0;
        busy <= 1'b1;
        done <= 1'b0;
      end
      if (state == S_EXEC) begin
        if (op == OP_HALT) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else if (taken) begin
          pc <= imm16[IMEM_AW-1:0];
        end else begin
          pc <= pc + 1'b1;
        end
        if (wr_rd) regs[rd] <= alu_res;
      end
      if (state == S_MEM) regs[rd] <= dmem_q;
    end
  end

  // Memories are not reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (write && address[16]) begin
      for (int b = 0; b < NB; b++)
        if (byteenable[b]) imem[address[IMEM_AW-1:0]][8*b +: 8] <= data_in[8*b +: 8];
    end
    if (state == S_FETCH) ir <= imem[pc];
  end

  // The core write comes after the host write so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (write && !address[16]) begin
      for (int b = 0; b < NB; b++)
        if (byteenable[b]) dmem[address[DMEM_AW-1:0]][8*b +: 8] <= data_in[8*b +: 8];
    end
    if (core_we) dmem[core_addr] <= regs[rd];
    if (state == S_EXEC && op == OP_LD) dmem_q <= dmem[core_addr];
  end

  always_ff @(posedge clk) begin
    if (reset_sink_reset) begin
      data_out <= '0;
    end else if (read) begin
      data_out <= address[16] ? imem[address[IMEM_AW-1:0]] : dmem[address[DMEM_AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sink_reset) begin
      data_out_control <= '0;
    end else if (read_control) begin
      data_out_control <= address_control ? {done, {(WIDTH-1-IMEM_AW){1'b0}}, pc}
                                          : {{(WIDTH-1){1'b0}}, busy};
    end
  end

endmodule

// File: tb/tb_mccp_videocard_core.sv
// Bench for mccp_videocard_core: an instruction-level model of the core
// predicts RAM contents, final PC and cycle counts; host and control read
// expectations are queued at issue and compared by a separate monitor.
module tb_mccp_videocard_core;

  logic        clk = 1'b0;
  logic        reset_sink_reset;
  logic [16:0] address;
  logic [31:0] data_in, data_out;
  logic [3:0]  byteenable;
  logic        write, read;
  logic        address_control;
  logic [31:0] data_in_control, data_out_control;
  logic        write_control, read_control;

  mccp_videocard_core dut (
    .clk(clk), .reset_sink_reset(reset_sink_reset),
    .address(address), .data_in(data_in), .data_out(data_out),
    .byteenable(byteenable), .write(write), .read(read),
    .address_control(address_control), .data_in_control(data_in_control),
    .data_out_control(data_out_control), .write_control(write_control),
    .read_control(read_control));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_imem [64];
  logic [31:0] m_dmem [256];
  logic [31:0] m_reg  [8];
  int          m_pc;
  bit          m_done;
  int          m_cycles;

  function automatic void model_write(input logic [16:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    logic [31:0] mask;
    mask = 0;
    for (int b = 0; b < 4; b++) if (be[b]) mask |= 32'hFF << (8 * b);
    if (a[16]) m_imem[a[5:0]] = (m_imem[a[5:0]] & ~mask) | (d & mask);
    else       m_dmem[a[7:0]] = (m_dmem[a[7:0]] & ~mask) | (d & mask);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_pc = 0;
    m_done = 0;
  endfunction

  // Runs the program from PC 0 for at most max_steps instructions.
  function automatic void model_run(input int max_steps);
    logic [31:0] ins, a, b, simm, ea;
    int op, rd, nxt;
    m_pc = 0; m_done = 0; m_cycles = 0;
    for (int s = 0; s < max_steps; s++) begin
      ins  = m_imem[m_pc];
      op   = int'(ins[31:28]);
      rd   = int'(ins[27:25]);
      a    = m_reg[ins[24:22]];
      b    = m_reg[ins[21:19]];
      simm = {{16{ins[15]}}, ins[15:0]};
      ea   = a + simm;
      nxt  = (m_pc + 1) % 64;
      m_cycles += 2;
      case (op)
        1:  m_reg[rd] = simm;
        2:  begin m_reg[rd] = m_dmem[ea % 256]; m_cycles += 1; end
        3:  m_dmem[ea % 256] = m_reg[rd];
        4:  m_reg[rd] = a + b;
        5:  m_reg[rd] = a - b;
        6:  m_reg[rd] = a & b;
        7:  m_reg[rd] = a | b;
        8:  m_reg[rd] = a ^ b;
        9:  m_reg[rd] = a << (b % 32);
        10: m_reg[rd] = a >> (b % 32);
        11: m_reg[rd] = ea;
        12: if (a == b) nxt = int'(ins[5:0]);
        13: if (a != b) nxt = int'(ins[5:0]);
        14: nxt = int'(ins[5:0]);
        15: begin m_done = 1; return; end
        default: ;
      endcase
      m_pc = nxt;
    end
  endfunction

  function automatic logic [31:0] enc(input int op, input int rd, input int ra,
                                      input int rb, input int imm);
    return {op[3:0], rd[2:0], ra[2:0], rb[2:0], 3'b000, imm[15:0]};
  endfunction

  function automatic logic [31:0] status_exp();
    logic [5:0] p;
    p = m_pc[5:0];
    return {m_done, 25'b0, p};
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] hexp_q[$];
  string       hname_q[$];
  logic [31:0] cexp_q[$];
  string       cname_q[$];
  logic        rd_d = 1'b0, rdc_d = 1'b0;

  always @(posedge clk) begin
    rd_d  <= read;
    rdc_d <= read_control;
  end

  always @(negedge clk) begin
    if (rd_d) begin
      if (hexp_q.size() == 0) begin
        n_total++;
        $display("FAIL host_read_unexpected: got %h expected none", data_out);
      end else check(hname_q.pop_front(), data_out, hexp_q.pop_front());
    end
    if (rdc_d) begin
      if (cexp_q.size() == 0) begin
        n_total++;
        $display("FAIL ctrl_read_unexpected: got %h expected none", data_out_control);
      end else check(cname_q.pop_front(), data_out_control, cexp_q.pop_front());
    end
  end

  // ---------------- drivers (called just after a negedge) ----------------
  task automatic host_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
    model_write(a, d, be);
    address = a; data_in = d; byteenable = be; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic host_read(input logic [16:0] a, input string nm);
    address = a; read = 1'b1;
    hexp_q.push_back(a[16] ? m_imem[a[5:0]] : m_dmem[a[7:0]]);
    hname_q.push_back(nm);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic ctrl_write(input logic sel, input logic [31:0] d);
    address_control = sel; data_in_control = d; write_control = 1'b1;
    @(negedge clk);
    write_control = 1'b0;
  endtask

  task automatic ctrl_read(input logic sel, input logic [31:0] exp, input string nm);
    address_control = sel; read_control = 1'b1;
    cexp_q.push_back(exp);
    cname_q.push_back(nm);
    @(negedge clk);
    read_control = 1'b0;
  endtask

  task automatic do_reset();
    reset_sink_reset = 1'b1;
    @(negedge clk);
    reset_sink_reset = 1'b0;
    model_reset();
    check("data_out_after_reset", data_out, 32'h0);
  endtask

  // Starts the core and checks busy falls exactly at the modelled cycle.
  // poke_kind 1: ignored CTRL start while busy; 2: host write to RAM[20].
  task automatic run_checked(input int poke_at, input int poke_kind, input bit chk_start);
    int t;
    int c;
    if (poke_kind == 2) model_write(17'd20, 32'hDEADBEEF, 4'hF);
    model_run(2000);
    c = m_cycles;
    ctrl_write(1'b0, 32'h1);
    t = 0;
    if (chk_start) begin
      ctrl_read(1'b1, 32'h0, "status_after_start");
      t = 1;
    end
    if (poke_kind != 0) begin
      repeat (poke_at - t) @(negedge clk);
      if (poke_kind == 1) ctrl_write(1'b0, 32'h1);
      else begin
        address = 17'd20; data_in = 32'hDEADBEEF; byteenable = 4'hF; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
      end
      t = poke_at + 1;
    end
    repeat (c - 1 - t) @(negedge clk);
    ctrl_read(1'b0, 32'h1, "busy_before_halt");
    ctrl_read(1'b0, 32'h0, "busy_after_halt");
    ctrl_read(1'b1, status_exp(), "status_done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_sink_reset = 1'b1;
    address = '0; data_in = '0; byteenable = '0; write = 1'b0; read = 1'b0;
    address_control = 1'b0; data_in_control = '0; write_control = 1'b0; read_control = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_sink_reset = 1'b0;
    check("data_out_reset", data_out, 32'h0);
    ctrl_read(1'b1, 32'h0, "status_reset");
    ctrl_read(1'b0, 32'h0, "ctrl_reset");

    // Fill RAM, then random partial writes and readback.
    for (int i = 0; i < 256; i++) host_write(17'(i), $urandom, 4'hF);
    for (int i = 0; i < 30; i++) host_write(17'($urandom_range(0, 255)), $urandom, 4'($urandom));
    for (int i = 0; i < 20; i++) host_read(17'($urandom_range(0, 255)), "ram_random");

    host_write(17'd7, 32'h0, 4'hF);
    host_write(17'd7, 32'hAABBCCDD, 4'b0010);
    host_read(17'd7, "byteenable_ram7");

    // Program 1; a host write to RAM[20] collides with the ST in the same cycle.
    host_write(17'h10000, enc(1, 1, 0, 0, 5), 4'hF);
    host_write(17'h10001, enc(1, 2, 0, 0, 7), 4'hF);
    host_write(17'h10002, enc(4, 3, 1, 2, 0), 4'hF);
    host_write(17'h10003, enc(3, 3, 0, 0, 20), 4'hF);
    host_write(17'h10004, enc(15, 0, 0, 0, 0), 4'hF);
    host_read(17'h10002, "imem_readback");
    run_checked(7, 2, 1'b0);
    host_read(17'd20, "prog1_ram20");

    // Sum loop with a CTRL start written mid-run.
    host_write(17'd0, 32'd4, 4'hF);
    for (int i = 1; i <= 4; i++) host_write(17'(i), 32'(i + 2), 4'hF);
    host_write(17'h10000, enc(1, 0, 0, 0, 0), 4'hF);
    host_write(17'h10001, enc(2, 1, 0, 0, 0), 4'hF);
    host_write(17'h10002, enc(1, 2, 0, 0, 0), 4'hF);
    host_write(17'h10003, enc(1, 3, 0, 0, 1), 4'hF);
    host_write(17'h10004, enc(12, 0, 1, 0, 10), 4'hF);
    host_write(17'h10005, enc(2, 4, 3, 0, 0), 4'hF);
    host_write(17'h10006, enc(4, 2, 2, 4, 0), 4'hF);
    host_write(17'h10007, enc(11, 3, 3, 0, 1), 4'hF);
    host_write(17'h10008, enc(11, 1, 1, 0, -1), 4'hF);
    host_write(17'h10009, enc(14, 0, 0, 0, 4), 4'hF);
    host_write(17'h1000A, enc(3, 2, 0, 0, 5), 4'hF);
    host_write(17'h1000B, enc(15, 0, 0, 0, 0), 4'hF);
    run_checked(6, 1, 1'b0);
    host_read(17'd5, "sum_ram5");

    // Rerun: done must clear and execution restart from PC 0.
    host_write(17'd0, 32'd2, 4'hF);
    run_checked(0, 0, 1'b1);
    host_read(17'd5, "rerun_ram5");

    // Random straight-line programs.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++)
        host_write(17'h10000 | 17'(i),
                   enc($urandom_range(0, 11), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 7), int'($urandom)), 4'hF);
      host_write(17'h10010, enc(15, 0, 0, 0, 0), 4'hF);
      run_checked(0, 0, 1'b0);
      for (int i = 0; i < 256; i++) host_read(17'(i), "rand_prog_ram");
    end

    // Reset in the middle of an endless program.
    host_write(17'd30, 32'h0, 4'hF);
    host_write(17'h10000, enc(1, 0, 0, 0, 0), 4'hF);
    host_write(17'h10001, enc(1, 1, 0, 0, 16'h55), 4'hF);
    host_write(17'h10002, enc(3, 1, 0, 0, 30), 4'hF);
    host_write(17'h10003, enc(14, 0, 0, 0, 3), 4'hF);
    model_run(10);
    ctrl_write(1'b0, 32'h1);
    repeat (15) @(negedge clk);
    do_reset();
    ctrl_read(1'b1, 32'h0, "status_after_midrun_reset");
    ctrl_read(1'b0, 32'h0, "ctrl_after_midrun_reset");
    repeat (4) @(negedge clk);
    ctrl_read(1'b1, 32'h0, "status_stays_idle");
    host_read(17'd30, "ram_persists_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(hexp_q.size() + cexp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
